// File: rtl/scr1_ahb_slv_mem.sv
// AHB-Lite responder in front of a single-port synchronous SRAM with 1-cycle read latency.
// Inserts optional data-phase wait states; illegal transfers get the two-cycle ERROR response.
module scr1_ahb_slv_mem #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACC, ST_RRESP, ST_ERR1, ST_ERR2} state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  hreadyout_q, hresp_q, mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  write_q, write_d;
  logic                  in_win, legal, can_accept, accept;
  logic                  unused_htrans;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    lane_be = 4'b0001 << a;
      2'd1:    lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  assign unused_htrans = htrans[0];

  assign in_win = (haddr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign legal  = in_win && (hsize <= 3'd2)
               && !((hsize == 3'd1) && haddr[0])
               && !((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  // A new address phase is only taken in cycles where this slave drives hreadyout high
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RRESP) || (state_q == ST_ERR2)
                   || ((state_q == ST_ACC) && write_q);
  assign accept     = hsel && hready && htrans[1] && can_accept;
  assign write_d    = (accept && legal) ? hwrite : write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACC;
      end
      ST_ACC:  state_d = write_q ? ST_IDLE : ST_RRESP;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (!legal) begin
        state_d = ST_ERR1;
      end else begin
        cnt_d   = WS;
        state_d = (WS != 4'd0) ? ST_WAIT : ST_ACC;
      end
    end
  end

  // Bus and memory strobes are registered from the next state so they are clean at the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1)
                       || ((state_d == ST_ACC) && !write_d));
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
      mem_req_q   <= (state_d == ST_ACC);
      mem_we_q    <= (state_d == ST_ACC) && write_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && legal) begin
      addr_q  <= haddr[ADDR_WIDTH-1:0];
      size_q  <= hsize[1:0];
      write_q <= hwrite;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q[ADDR_WIDTH-1:2];
  assign mem_be    = lane_be(size_q, addr_q[1:0]);
  assign mem_wdata = hwdata;
  assign hrdata    = (state_q == ST_RRESP) ? mem_rdata : 32'h0;

endmodule
